// File: rtl/siso_word_collector.sv
// siso_word_collector: reassembles a serial bit stream (MSB- or LSB-first) into
// parallel words and queues them in a small valid/ready output FIFO.
module siso_word_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sin,
  input  logic                     i_sin_valid,
  input  logic                     i_left,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_word,
  output logic                     o_word_valid,
  input  logic                     i_word_ready,
  output logic [$clog2(WIDTH)-1:0] o_bit_count,
  output logic                     o_busy,
  output logic                     o_overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_bit_count, w_bit_count_nx;
  logic [WIDTH-1:0] r_asm, w_asm_nx, r_word, w_head;
  logic             r_dir, w_dir, w_done, w_pop, w_full, w_push, w_ovf, r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd, r_wr, w_rd_nx;
  logic [OW-1:0]    r_count;

  // The first bit of a word uses the live Left; later bits use the latched direction.
  always_comb begin
    w_dir          = (r_state == IDLE) ? i_left : r_dir;
    w_asm_nx       = w_dir ? {r_asm[WIDTH-2:0], i_sin} : {i_sin, r_asm[WIDTH-1:1]};
    w_done         = i_sin_valid && r_state == COLLECT && r_bit_count == CW'(WIDTH - 1);
    w_state_nx     = i_sin_valid ? (w_done ? IDLE : COLLECT) : r_state;
    w_bit_count_nx = i_sin_valid ? (w_done ? '0 : r_bit_count + 1'b1) : r_bit_count;
  end

  assign w_pop   = o_word_valid & i_word_ready;
  assign w_full  = r_count == OW'(DEPTH);
  assign w_push  = w_done & (~w_full | w_pop);
  assign w_ovf   = w_done & w_full & ~w_pop;
  assign w_rd_nx = w_pop ? r_rd + 1'b1 : r_rd;
  // Forward the incoming word when it becomes the head on this same edge.
  assign w_head  = (w_push && w_rd_nx == r_wr) ? w_asm_nx : r_mem[w_rd_nx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_bit_count <= '0;
      r_asm       <= '0;
      r_dir       <= 1'b0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_count     <= '0;
      r_word      <= '0;
      r_overflow  <= 1'b0;
    end else if (i_flush) begin
      r_state     <= IDLE;
      r_bit_count <= '0;
      r_asm       <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_count     <= '0;
      r_word      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_count <= w_bit_count_nx;
      if (i_sin_valid) r_asm <= w_asm_nx;
      if (i_sin_valid && r_state == IDLE) r_dir <= i_left;
      r_rd        <= w_rd_nx;
      if (w_push) r_wr <= r_wr + 1'b1;
      r_count     <= r_count + OW'(w_push) - OW'(w_pop);
      r_word      <= w_head;
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= w_asm_nx;
  end

  assign o_word       = r_word;
  assign o_word_valid = r_count != '0;
  assign o_bit_count  = r_bit_count;
  assign o_busy       = r_state == COLLECT;
  assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_siso_word_collector.sv
// tb_siso_word_collector: random and directed serial streams; a queue-based model
// predicts accepted words and a negedge monitor checks every DUT output.
module tb_siso_word_collector;
  localparam int W = 16;
  localparam int D = 2;

  logic         clk, rst_n, sin, sin_valid, left, flush, word_ready;
  logic [W-1:0] o_word;
  logic         o_word_valid, o_busy, o_overflow;
  logic [3:0]   o_bit_count;

  int total = 0;
  int bad = 0;

  bit           bits[$];
  logic [W-1:0] sb_q[$];
  int           m_occ = 0;
  bit           m_ovf = 0;
  bit           m_dir = 0;

  siso_word_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sin(sin), .i_sin_valid(sin_valid),
    .i_left(left), .i_flush(flush), .o_word(o_word), .o_word_valid(o_word_valid),
    .i_word_ready(word_ready), .o_bit_count(o_bit_count), .o_busy(o_busy),
    .o_overflow(o_overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: collect bits in a list, build the word arithmetically once W bits arrive.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      bits.delete();
      sb_q.delete();
      m_occ = 0;
      m_ovf = 0;
    end else begin
      bit pop;
      logic [W-1:0] w;
      pop = m_occ > 0 && word_ready;
      if (sin_valid) begin
        if (bits.size() == 0) m_dir = left;
        bits.push_back(sin);
        if (bits.size() == W) begin
          w = '0;
          for (int i = 0; i < W; i++)
            if (m_dir) w[W-1-i] = bits[i];
            else w[i] = bits[i];
          if (m_occ < D || pop) begin
            sb_q.push_back(w);
            m_occ++;
          end else m_ovf = 1;
          bits.delete();
        end
      end
      if (pop) m_occ--;
    end
  end

  always @(negedge clk) begin
    chk("valid", {31'd0, o_word_valid}, {31'd0, m_occ != 0});
    chk("busy", {31'd0, o_busy}, {31'd0, bits.size() != 0});
    chk("bitcount", {28'd0, o_bit_count}, bits.size());
    chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    if (o_word_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL word got=%0h want=<none> at %0t", o_word, $time);
      end else begin
        chk("word", {16'd0, o_word}, {16'd0, sb_q[0]});
        if (word_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive(input bit sv, input bit s, input bit l, input bit rdy, input bit fl);
    @(posedge clk);
    #2;
    sin_valid = sv; sin = s; left = l; word_ready = rdy; flush = fl;
  endtask

  // rdy_from: bit index from which the consumer is ready (0 = always, 16 = never).
  task automatic send_word(input logic [W-1:0] w, input bit l, input int tog,
                           input int gap, input int rdy_from);
    for (int i = 0; i < W; i++) begin
      drive(1, l ? w[W-1-i] : w[i], (i >= tog) ? ~l : l, i >= rdy_from, 0);
      if (i != W - 1)
        for (int g = 0; g < gap; g++) drive(0, 0, l, rdy_from == 0, 0);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, rdy, 0);
  endtask

  initial begin
    rst_n = 0; sin = 0; sin_valid = 0; left = 0; flush = 0; word_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_word", {16'd0, o_word}, 0);
    chk("rst_valid", {31'd0, o_word_valid}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    rst_n = 1;

    send_word(16'hA5C3, 1, W, 0, 0);
    idle(3, 1);
    send_word(16'h1234, 0, 8, 3, 0);
    idle(3, 1);

    send_word(16'h0001, 1, W, 0, W);
    send_word(16'h0002, 1, W, 0, W);
    send_word(16'h0003, 1, W, 0, W);
    idle(2, 0);
    idle(4, 1);
    drive(0, 0, 0, 1, 1);

    send_word(16'hAAAA, 1, W, 0, W);
    send_word(16'hBBBB, 1, W, 0, W);
    send_word(16'hCCCC, 1, W, 0, W - 1);
    idle(5, 1);

    send_word(16'h5A5A, 0, W, 0, W);
    for (int i = 0; i < 9; i++) drive(1, i[0], 1, 0, 0);
    drive(1, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 0);
    send_word(16'h0F1E, 1, W, 0, 0);
    idle(3, 1);

    send_word(16'h7777, 1, W, 0, W);
    for (int i = 0; i < 7; i++) drive(1, 1, 1, 0, 0);
    @(posedge clk);
    #2;
    sin_valid = 0;
    #1;
    rst_n = 0;
    #1;
    chk("async_bitcount", {28'd0, o_bit_count}, 0);
    chk("async_busy", {31'd0, o_busy}, 0);
    chk("async_valid", {31'd0, o_word_valid}, 0);
    @(negedge clk);
    rst_n = 1;
    idle(3, 1);

    for (int n = 0; n < 40; n++) begin
      int rf;
      rf = $urandom_range(0, 3) == 0 ? W : ($urandom_range(0, 1) ? 0 : $urandom_range(1, W - 1));
      send_word(16'($urandom), 1'($urandom), $urandom_range(1, W), $urandom_range(0, 2), rf);
      idle($urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 7) == 0) drive(0, 0, 0, 1'($urandom), 1);
    end
    idle(6, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
